// File: rtl/if_fetch_unit.sv
//------------------------------------------------------------------------------
// Module     : if_fetch_unit
// Description: Instruction-fetch stage. Owns the PC, addresses a combinational
//              instruction memory, registers the returned instruction with its
//              PC for decode over a valid/ready handshake, accepts redirects
//              and counts delivered instructions.
//              Optional feature macro: IF_HALT_ON_BREAK_EN (halt on MIPS break).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module if_fetch_unit #(
  parameter logic [`ADDR_LEN-1:0] RESET_PC = '0,
  parameter int                   CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic [`ADDR_LEN-1:0]  imem_addr,
  input  logic [`INSTR_LEN-1:0] imem_inst,
  input  logic                  redirect_valid,
  input  logic [`ADDR_LEN-1:0]  redirect_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`INSTR_LEN-1:0] out_inst,
  output logic [`ADDR_LEN-1:0]  out_pc,
  output logic                  misalign_err,
  output logic [CNT_W-1:0]      fetch_count,
  output logic [1:0]            state_o
);

  localparam int unsigned        c_AW      = `ADDR_LEN;
  localparam int unsigned        c_IW      = `INSTR_LEN;
  localparam logic [c_AW-1:0]    c_PC_STEP = c_AW'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [c_AW-1:0]   pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [c_IW-1:0]   out_inst_q, out_inst_d;
  logic [c_AW-1:0]   out_pc_q, out_pc_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              w_load;
  logic              w_xfer;

  // The output register can take a new word when empty or being drained.
  assign w_load = !out_valid_q || out_ready;
  assign w_xfer = out_valid_q && out_ready;

`ifdef IF_HALT_ON_BREAK_EN
  logic w_is_break;
  // MIPS break: SPECIAL opcode with funct 0x0D; code field is ignored.
  assign w_is_break = (imem_inst[31:26] == 6'b000000) && (imem_inst[5:0] == 6'b001101);
`endif

  // Next-state logic: redirect has priority over capture, stall and halt.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;

    if (redirect_valid) begin
      pc_d        = {redirect_target[c_AW-1:2], 2'b00};
      out_valid_d = 1'b0;
      if (state_q == S_HALT) begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_en) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (w_load) begin
            out_inst_d  = imem_inst;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + c_PC_STEP;
`ifdef IF_HALT_ON_BREAK_EN
            if (w_is_break) begin
              pc_d    = pc_q;
              state_d = S_HALT;
            end
`endif
          end
        end
        S_HALT: begin
`ifdef IF_HALT_ON_BREAK_EN
          // The break word is still delivered; once taken, nothing more is offered.
          if (w_xfer) begin
            out_valid_d = 1'b0;
          end
`else
          state_d = S_IDLE;
`endif
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Sticky misalignment flag and delivered-instruction counter.
  always_comb begin
    misalign_d = misalign_q;
    count_d    = count_q;
    if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
    if (w_xfer) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      misalign_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      misalign_q  <= misalign_d;
      count_q     <= count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = out_valid_q;
  assign out_inst     = out_inst_q;
  assign out_pc       = out_pc_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
//------------------------------------------------------------------------------
// Module     : tb_if_fetch_unit
// Description: Self-checking bench for if_fetch_unit with an expected-output
//              queue and a decoupled monitor.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic [1:0]  state_o;

  logic [31:0] mem [0:63];
  exp_t        exp_q [$];
  int          total;
  int          bad;

  if_fetch_unit #(
    .RESET_PC (32'h0),
    .CNT_W    (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count),
    .state_o         (state_o)
  );

  assign imem_inst = mem[imem_addr[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem[pc[7:2]];
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake seen on the falling edge must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer_pc", out_pc, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc", out_pc, e.pc);
          check("xfer_inst", out_inst, e.inst);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | (i << 2);
    mem[0] = 32'h012A4020;
    mem[1] = 32'h014B5822;
`ifdef IF_HALT_ON_BREAK_EN
    mem[2] = 32'h0000000D;
`else
    mem[2] = 32'h02328820;
`endif

    rst_n           = 1'b0;
    fetch_en        = 1'b0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;

    #3;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_state", {30'b0, state_o}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // IDLE holds without fetch_en
    step();
    check("idle_state", {30'b0, state_o}, 32'h0);
    check("idle_pc", imem_addr, 32'h0);
    check("idle_valid", {31'b0, out_valid}, 32'h0);

    // Streaming fetch
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    push(32'h0);
    push(32'h4);
    step();
    check("run_state", {30'b0, state_o}, 32'h1);
    check("run_first_valid", {31'b0, out_valid}, 32'h0);
    step();
    check("cap0_pc", out_pc, 32'h0);
    check("cap0_valid", {31'b0, out_valid}, 32'h1);
    step();
    check("cnt_after_1", fetch_count, 32'd1);
    check("cap1_pc", out_pc, 32'h4);
    out_ready = 1'b0;
    fetch_en  = 1'b0;

    // Stall three cycles: everything holds
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc", out_pc, 32'h4);
      check("stall_inst", out_inst, 32'h014B5822);
      check("stall_addr", imem_addr, 32'h8);
      check("stall_cnt", fetch_count, 32'd1);
      check("stall_valid", {31'b0, out_valid}, 32'h1);
      check("stall_state", {30'b0, state_o}, 32'h1);
    end
    out_ready = 1'b1;
    step();
    check("cnt_after_2", fetch_count, 32'd2);
    check("resume_pc", out_pc, 32'h8);
    check("resume_inst", out_inst, mem[2]);

    // Aligned redirect while stalled flushes the held word
    out_ready       = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", {31'b0, out_valid}, 32'h0);
    check("redir_addr", imem_addr, 32'h10);
    check("redir_misalign", {31'b0, misalign_err}, 32'h0);
    check("redir_state", {30'b0, state_o}, 32'h1);
    out_ready = 1'b1;
    push(32'h10);
    step();
    check("redir_cap_pc", out_pc, 32'h10);
    check("redir_cap_valid", {31'b0, out_valid}, 32'h1);
    check("redir_cap_mis", {31'b0, misalign_err}, 32'h0);

    // Misaligned redirect in the same cycle as a transfer
    redirect_valid  = 1'b1;
    redirect_target = 32'h13;
    step();
    check("mis_cnt", fetch_count, 32'd3);
    check("mis_valid", {31'b0, out_valid}, 32'h0);
    check("mis_addr", imem_addr, 32'h10);
    check("mis_flag", {31'b0, misalign_err}, 32'h1);
    redirect_target = 32'h20;
    step();
    redirect_valid = 1'b0;
    check("mis_sticky", {31'b0, misalign_err}, 32'h1);
    check("redir20_addr", imem_addr, 32'h20);
    push(32'h20);
    step();
    step();
    check("cnt_after_4", fetch_count, 32'd4);
    check("cap24_pc", out_pc, 32'h24);
    out_ready = 1'b0;

    // PC wraps at the top of the address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("top_mis_sticky", {31'b0, misalign_err}, 32'h1);
    out_ready = 1'b1;
    push(32'hFFFF_FFFC);
    step();
    check("top_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);
    step();
    out_ready = 1'b0;
    check("cnt_after_5", fetch_count, 32'd5);
    check("wrap_pc", out_pc, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h4);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_cnt", fetch_count, 32'h0);
    check("arst_state", {30'b0, state_o}, 32'h0);
    check("arst_mis", {31'b0, misalign_err}, 32'h0);
    step();
    rst_n = 1'b1;

`ifdef IF_HALT_ON_BREAK_EN
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    push(32'h0);
    push(32'h4);
    push(32'h8);
    step();
    step();
    step();
    step();
    check("brk_state", {30'b0, state_o}, 32'h2);
    check("brk_pc", out_pc, 32'h8);
    check("brk_addr", imem_addr, 32'h8);
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_valid", {31'b0, out_valid}, 32'h0);
      check("halt_state", {30'b0, state_o}, 32'h2);
      check("halt_pc", out_pc, 32'h8);
      check("halt_cnt", fetch_count, 32'd3);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0;
    push(32'h0);
    step();
    redirect_valid = 1'b0;
    check("exit_state", {30'b0, state_o}, 32'h1);
    check("exit_addr", imem_addr, 32'h0);
    step();
    check("resume0_pc", out_pc, 32'h0);
    step();
    out_ready = 1'b0;
    check("resume_cnt", fetch_count, 32'd4);
`endif

    step();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
